// File: rtl/cla_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_sched_pkg
// Purpose  : Shared types and helpers for the pipelined-adder issue scheduler.
// Revision : 1.0  initial release
// ============================================================================
package cla_sched_pkg;

    // Largest supported requester count; sizes the tag ID field.
    localparam int unsigned N_MAX = 8;
    localparam int unsigned IDW   = $clog2(N_MAX);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    function automatic int lat(input int s);
        return s + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_issue_sched_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb
// Purpose  : Combinational round-robin arbiter, one-hot grant starting at ptr.
// Revision : 1.0  initial release
// ============================================================================
module rr_arb
    import cla_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int j = 0; j < N; j++) begin
            w_idx = (int'(ptr) + j) % N;
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = IDW'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cla_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : cla_issue_sched
// Purpose  : Shares one pipelined adder among N requesters with RR issue,
//            tag tracking, per-requester credit limits and result routing.
// Revision : 1.0  initial release
// ============================================================================
module cla_issue_sched
    import cla_sched_pkg::*;
#(
    parameter int W       = 128,
    parameter int S       = 4,
    parameter int N       = 4,
    parameter int MAX_OUT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_op1,
    input  logic [N*W-1:0] req_op2,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   resp_valid,
    output logic [W-1:0]   resp_data,
    output logic           add_rstn,
    output logic [W-1:0]   add_op1,
    output logic [W-1:0]   add_op2,
    output logic           add_valid_op,
    input  logic [W-1:0]   add_res,
    input  logic           add_valid,
    output logic           err
);

    localparam int c_lat = lat(S);
    localparam int c_cw  = $clog2(MAX_OUT + 1);

    logic [IDW-1:0]    r_ptr_q, w_ptr_d;
    tag_t [c_lat:0]    r_tag_q, w_tag_d;
    logic [c_cw-1:0]   r_cnt_q [N];
    logic [c_cw-1:0]   w_cnt_d [N];
    logic [N-1:0]      r_resp_valid_q, w_resp_valid_d;
    logic [W-1:0]      r_resp_data_q, w_resp_data_d;
    logic [W-1:0]      r_add_op1_q, w_add_op1_d;
    logic [W-1:0]      r_add_op2_q, w_add_op2_d;
    logic              r_add_valid_op_q, w_add_valid_op_d;
    logic              r_add_rstn_q;
    logic              r_err_q, w_err_d;

    logic [N-1:0]      w_elig;
    logic [N-1:0]      w_gnt;
    logic [IDW-1:0]    w_gnt_idx;
    logic              w_gnt_any;
    logic [N-1:0]      w_ret;
    tag_t              w_tail;

    // No issue while the adder is (or is about to be) held in reset.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N; i++) begin
            w_elig[i] = req_valid[i] && (r_cnt_q[i] < c_cw'(MAX_OUT))
                        && !rst && r_add_rstn_q;
        end
    end

    rr_arb #(
        .N       (N)
    ) u_rr_arb (
        .req     (w_elig),
        .ptr     (r_ptr_q),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_gnt_any = |w_gnt;
    assign w_tail    = r_tag_q[c_lat];

    always_comb begin
        w_ptr_d          = r_ptr_q;
        w_add_op1_d      = r_add_op1_q;
        w_add_op2_d      = r_add_op2_q;
        w_add_valid_op_d = w_gnt_any;
        w_tag_d          = '0;
        w_ret            = '0;
        w_resp_data_d    = r_resp_data_q;

        if (w_gnt_any) begin
            w_ptr_d     = (int'(w_gnt_idx) == N - 1) ? '0 : w_gnt_idx + 1'b1;
            w_add_op1_d = req_op1[int'(w_gnt_idx)*W +: W];
            w_add_op2_d = req_op2[int'(w_gnt_idx)*W +: W];
        end

        w_tag_d[0].vld = w_gnt_any;
        w_tag_d[0].id  = w_gnt_idx;
        for (int k = 1; k <= c_lat; k++) begin
            w_tag_d[k] = r_tag_q[k-1];
        end

        for (int i = 0; i < N; i++) begin
            w_ret[i] = w_tail.vld && (w_tail.id == IDW'(i));
        end
        w_resp_valid_d = w_ret;
        if (w_tail.vld) begin
            w_resp_data_d = add_res;
        end

        // A grant and a return in the same cycle cancel out.
        for (int i = 0; i < N; i++) begin
            w_cnt_d[i] = r_cnt_q[i];
            if (w_gnt[i] && !w_ret[i]) begin
                w_cnt_d[i] = r_cnt_q[i] + 1'b1;
            end else if (!w_gnt[i] && w_ret[i]) begin
                w_cnt_d[i] = r_cnt_q[i] - 1'b1;
            end
        end

        // While the adder is in reset its valid output is not meaningful.
        w_err_d = r_err_q || (r_add_rstn_q && (add_valid != w_tail.vld));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q          <= '0;
            r_tag_q          <= '0;
            r_resp_valid_q   <= '0;
            r_resp_data_q    <= '0;
            r_add_op1_q      <= '0;
            r_add_op2_q      <= '0;
            r_add_valid_op_q <= 1'b0;
            r_add_rstn_q     <= 1'b0;
            r_err_q          <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_cnt_q[i] <= '0;
            end
        end else begin
            r_ptr_q          <= w_ptr_d;
            r_tag_q          <= w_tag_d;
            r_resp_valid_q   <= w_resp_valid_d;
            r_resp_data_q    <= w_resp_data_d;
            r_add_op1_q      <= w_add_op1_d;
            r_add_op2_q      <= w_add_op2_d;
            r_add_valid_op_q <= w_add_valid_op_d;
            r_add_rstn_q     <= 1'b1;
            r_err_q          <= w_err_d;
            for (int i = 0; i < N; i++) begin
                r_cnt_q[i] <= w_cnt_d[i];
            end
        end
    end

    assign req_ready    = w_gnt;
    assign resp_valid   = r_resp_valid_q;
    assign resp_data    = r_resp_data_q;
    assign add_rstn     = r_add_rstn_q;
    assign add_op1      = r_add_op1_q;
    assign add_op2      = r_add_op2_q;
    assign add_valid_op = r_add_valid_op_q;
    assign err          = r_err_q;

endmodule
`default_nettype wire
